poly_tone_gen: RTL and testbench

Parametrised multi-voice tone generator for the synth audio path. Each of VOICES voices runs its own phase accumulator with a programmable increment and waveform mode. A shared sample-rate divider advances all voices together. A sequential scanner then sums the gated voices into one mixed sample, which goes to the audio codec interface.

---
 rtl/synth_pkg.sv | 18 +
 rtl/poly_tone_gen_if.sv | 29 ++
 rtl/poly_tone_gen_voice.sv | 83 ++++++++
 rtl/poly_tone_gen.sv | 119 +++++++++++
 tb/tb_poly_tone_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared encodings for the polyphonic tone generator: waveform modes and
// the mixer scan FSM states.
package synth_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/poly_tone_gen_if.sv
// Voice configuration and mixed-sample output bundle of poly_tone_gen.
// The tone generator sits on the slave side; the controller or codec side is the master.
interface poly_tone_gen_if #(
  parameter int VOICES = 4,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8
);
  localparam int IDX_W = $clog2(VOICES);
  localparam int SUM_W = OUT_W + IDX_W;

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_voice;
  logic [ACC_W-1:0]  cfg_inc;
  logic [1:0]        cfg_mode;
  logic              cfg_gate;
  logic [VOICES-1:0] outs;
  logic [SUM_W-1:0]  sample_out;
  logic              sample_valid;

  modport master (
    output cfg_we, cfg_voice, cfg_inc, cfg_mode, cfg_gate,
    input  outs, sample_out, sample_valid
  );

  modport slave (
    input  cfg_we, cfg_voice, cfg_inc, cfg_mode, cfg_gate,
    output outs, sample_out, sample_valid
  );
endinterface

// File: rtl/poly_tone_gen_voice.sv
// One tone voice: inc/mode/gate/acc registers, tick-driven phase accumulation
// and the combinational waveform sample. GATE_PHASE_SYNC_EN: gate 0->1 write clears acc.
module tone_voice
  import synth_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             tick,
  input  logic             cfg_sel,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_gate,
  output logic [OUT_W-1:0] sample,
  output logic             out_bit
);

  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  mode_e            mode_q, mode_d;
  logic             gate_q, gate_d;
  logic             out_q, out_d;
  logic [OUT_W-1:0] saw;
  logic [OUT_W-1:0] half;

  always_comb begin
    inc_d  = inc_q;
    mode_d = mode_q;
    gate_d = gate_q;
    acc_d  = acc_q;
    // The tick add uses the registered inc/gate, so a same-edge write only affects later ticks.
    if (tick && gate_q) begin
      acc_d = acc_q + inc_q;
    end
    if (cfg_sel) begin
      inc_d  = cfg_inc;
      mode_d = mode_e'(cfg_mode);
      gate_d = cfg_gate;
`ifdef GATE_PHASE_SYNC_EN
      if (cfg_gate && !gate_q) begin
        acc_d = '0;
      end
`endif
    end
    out_d = acc_d[ACC_W-1] & gate_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      inc_q  <= '0;
      mode_q <= MODE_SQUARE;
      gate_q <= 1'b0;
      acc_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      inc_q  <= inc_d;
      mode_q <= mode_d;
      gate_q <= gate_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
    end
  end

  assign saw  = acc_q[ACC_W-1 -: OUT_W];
  assign half = acc_q[ACC_W-2 -: OUT_W];

  always_comb begin
    sample = '0;
    if (gate_q) begin
      case (mode_q)
        MODE_SQUARE: sample = {OUT_W{acc_q[ACC_W-1]}};
        MODE_SAW:    sample = saw;
        MODE_TRI:    sample = acc_q[ACC_W-1] ? ~half : half;
        default:     sample = '0;
      endcase
    end
  end

  assign out_bit = out_q;

endmodule

// File: rtl/poly_tone_gen.sv
// Multi-voice tone generator: sample-rate divider, VOICES tone_voice instances
// and a one-voice-per-cycle scan FSM that mixes the gated voices into sample_out.
//
// state | meaning
// IDLE  | waiting for the sample tick
// SCAN  | adding voice idx into the running sum, one voice per cycle
// DONE  | sample_out just loaded, sample_valid high for this cycle
module poly_tone_gen
  import synth_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 8,
  parameter int SAMPLE_DIV = 1024
) (
  input  logic              clock,
  input  logic              resetn,
  poly_tone_gen_if.slave    bus
);

  localparam int IDX_W = $clog2(VOICES);
  localparam int SUM_W = OUT_W + IDX_W;
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VOICES - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic [OUT_W-1:0]  voice_s [VOICES];
  logic [VOICES-1:0] out_bits;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W-1:0]  sample_q, sample_d;
  logic              valid_q, valid_d;
  logic [SUM_W-1:0]  sum_next;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  for (genvar i = 0; i < VOICES; i++) begin : g_voice
    tone_voice #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_voice (
      .clock    (clock),
      .resetn   (resetn),
      .tick     (tick),
      .cfg_sel  (bus.cfg_we && (bus.cfg_voice == IDX_W'(i))),
      .cfg_inc  (bus.cfg_inc),
      .cfg_mode (bus.cfg_mode),
      .cfg_gate (bus.cfg_gate),
      .sample   (voice_s[i]),
      .out_bit  (out_bits[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    sum_next = sum_q + SUM_W'(voice_s[idx_q]);
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      SCAN: begin
        sum_d = sum_next;
        idx_d = idx_q + IDX_W'(1);
        // Load the output on the last scan edge so it is visible in the same cycle as the valid pulse.
        if (idx_q == IDX_LAST) begin
          state_d  = DONE;
          idx_d    = '0;
          sample_d = sum_next;
          valid_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      sum_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.outs         = out_bits;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_poly_tone_gen.sv
// Directed bench for poly_tone_gen with VOICES=4, ACC_W=8, OUT_W=4, SAMPLE_DIV=8.
module tb_poly_tone_gen;
  import synth_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [5:0] exp_tri [8] = '{6'd4, 6'd8, 6'd12, 6'd15, 6'd11, 6'd7, 6'd3, 6'd0};

  poly_tone_gen_if #(.VOICES(4), .ACC_W(8), .OUT_W(4)) bus ();

  poly_tone_gen #(
    .VOICES     (4),
    .ACC_W      (8),
    .OUT_W      (4),
    .SAMPLE_DIV (8)
  ) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    resetn        = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_voice = '0;
    bus.cfg_inc   = '0;
    bus.cfg_mode  = '0;
    bus.cfg_gate  = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic write_voice(input int v, input logic [7:0] inc, input logic [1:0] mode,
                             input logic gate);
    bus.cfg_voice = 2'(v);
    bus.cfg_inc   = inc;
    bus.cfg_mode  = mode;
    bus.cfg_gate  = gate;
    bus.cfg_we    = 1'b1;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic wait_sample(output logic [5:0] s, output bit ok);
    ok = 1'b0;
    s  = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.sample_valid) begin
        s  = bus.sample_out;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.cfg_we    = 1'b0;
    bus.cfg_voice = '0;
    bus.cfg_inc   = '0;
    bus.cfg_mode  = '0;
    bus.cfg_gate  = 1'b0;
    #2 resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outs !== 4'd0) begin
      errors++; $display("FAIL reset_outs: got %b expected 0000", bus.outs);
    end
    checks++;
    if (bus.sample_out !== 6'd0) begin
      errors++; $display("FAIL reset_sample: got %0d expected 0", bus.sample_out);
    end
    checks++;
    if (bus.sample_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.sample_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_idle_pulses();
    logic exp_v;
    apply_reset();
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = (k >= 12) && (((k - 12) % 8) == 0);
      checks++;
      if (bus.sample_valid !== exp_v) begin
        errors++; $display("FAIL idle_valid[%0d]: got %b expected %b", k, bus.sample_valid, exp_v);
      end
      checks++;
      if (bus.outs !== 4'd0 || bus.sample_out !== 6'd0) begin
        errors++; $display("FAIL idle_zero[%0d]: got outs %b sample %0d expected 0", k, bus.outs, bus.sample_out);
      end
    end
  endtask

  task automatic test_saw();
    logic [5:0] s;
    bit ok;
    apply_reset();
    write_voice(0, 8'd16, MODE_SAW, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      wait_sample(s, ok);
      checks++;
      if (!ok || s !== 6'(i % 16)) begin
        errors++; $display("FAIL saw[%0d]: got %0d (seen %0d) expected %0d", i, s, ok, i % 16);
      end
    end
  endtask

  task automatic test_square();
    logic [5:0] s;
    bit ok;
    apply_reset();
    write_voice(1, 8'd128, MODE_SQUARE, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_sample(s, ok);
      checks++;
      if (!ok || s !== ((i % 2 == 0) ? 6'd15 : 6'd0)) begin
        errors++; $display("FAIL square[%0d]: got %0d (seen %0d) expected %0d", i, s, ok, (i % 2 == 0) ? 15 : 0);
      end
      checks++;
      if (bus.outs !== ((i % 2 == 0) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL square_outs[%0d]: got %b expected %b", i, bus.outs, (i % 2 == 0) ? 4'b0010 : 4'b0000);
      end
    end
  endtask

  task automatic test_triangle();
    logic [5:0] s;
    bit ok;
    apply_reset();
    write_voice(2, 8'd32, MODE_TRI, 1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_sample(s, ok);
      checks++;
      if (!ok || s !== exp_tri[i]) begin
        errors++; $display("FAIL tri[%0d]: got %0d (seen %0d) expected %0d", i, s, ok, exp_tri[i]);
      end
    end
  endtask

  task automatic test_tick_write();
    logic [5:0] s;
    bit ok;
    apply_reset();
    write_voice(0, 8'd16, MODE_SAW, 1'b1);
    wait_sample(s, ok);
    checks++;
    if (!ok || s !== 6'd1) begin
      errors++; $display("FAIL tickwr_first: got %0d (seen %0d) expected 1", s, ok);
    end
    // valid is at tick+5, so the next tick is three cycles on
    repeat (3) @(negedge clk);
    write_voice(0, 8'd32, MODE_SAW, 1'b1);
    wait_sample(s, ok);
    checks++;
    if (!ok || s !== 6'd2) begin
      errors++; $display("FAIL tickwr_old_inc: got %0d (seen %0d) expected 2", s, ok);
    end
    wait_sample(s, ok);
    checks++;
    if (!ok || s !== 6'd4) begin
      errors++; $display("FAIL tickwr_new_inc: got %0d (seen %0d) expected 4", s, ok);
    end
  endtask

  task automatic test_all_voices_reset();
    logic [5:0] s;
    bit ok;
    apply_reset();
    for (int v = 0; v < 4; v++) write_voice(v, 8'd128, MODE_SQUARE, 1'b1);
    wait_sample(s, ok);
    checks++;
    if (!ok || s !== 6'd60) begin
      errors++; $display("FAIL mix60: got %0d (seen %0d) expected 60", s, ok);
    end
    checks++;
    if (bus.outs !== 4'b1111) begin
      errors++; $display("FAIL mix_outs: got %b expected 1111", bus.outs);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.sample_out !== 6'd60) begin
      errors++; $display("FAIL hold60: got %0d expected 60", bus.sample_out);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.sample_out !== 6'd0 || bus.outs !== 4'd0 || bus.sample_valid !== 1'b0) begin
      errors++; $display("FAIL midscan_reset: got sample %0d outs %b valid %b expected 0 0000 0",
                         bus.sample_out, bus.outs, bus.sample_valid);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.sample_valid !== (k == 12)) begin
        errors++; $display("FAIL post_reset_valid[%0d]: got %b expected %b", k, bus.sample_valid, k == 12);
      end
    end
    checks++;
    if (bus.sample_out !== 6'd0) begin
      errors++; $display("FAIL post_reset_sample: got %0d expected 0", bus.sample_out);
    end
  endtask

  task automatic test_gate_resync();
    logic [5:0] s;
    logic [5:0] exp_a;
    logic [5:0] exp_b;
    bit ok;
`ifdef GATE_PHASE_SYNC_EN
    exp_a = 6'd1;
    exp_b = 6'd2;
`else
    exp_a = 6'd4;
    exp_b = 6'd5;
`endif
    apply_reset();
    write_voice(0, 8'd16, MODE_SAW, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      wait_sample(s, ok);
      checks++;
      if (!ok || s !== 6'(i)) begin
        errors++; $display("FAIL resync_pre[%0d]: got %0d (seen %0d) expected %0d", i, s, ok, i);
      end
    end
    write_voice(0, 8'd16, MODE_SAW, 1'b0);
    write_voice(0, 8'd16, MODE_SAW, 1'b1);
    wait_sample(s, ok);
    checks++;
    if (!ok || s !== exp_a) begin
      errors++; $display("FAIL resync_first: got %0d (seen %0d) expected %0d", s, ok, exp_a);
    end
    wait_sample(s, ok);
    checks++;
    if (!ok || s !== exp_b) begin
      errors++; $display("FAIL resync_second: got %0d (seen %0d) expected %0d", s, ok, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_idle_pulses();
    test_saw();
    test_square();
    test_triangle();
    test_tick_write();
    test_all_voices_reset();
    test_gate_resync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
